// File: rtl/vol_ramp_ctrl_pkg.sv
// Shared types for the volume ramp controller: level range, FSM states and
// the level-to-thermometer gain encoding.
package vol_pkg;

    localparam int MAX_LEVEL = 8;

    typedef logic [3:0] level_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        DONE = 2'd2
    } state_t;

    // Level L maps to L low bits set; level 8 is all ones.
    function automatic logic [7:0] therm(input level_t l);
        logic [8:0] t;
        t = (9'd1 << l) - 9'd1;
        return t[7:0];
    endfunction

endpackage

// File: rtl/vol_ramp_ctrl_if.sv
// Preset request channel between a requester (master) and vol_ramp_ctrl (slave).
interface vol_ramp_ctrl_if;
    import vol_pkg::*;

    // Handshake: master raises preset_req with preset_level stable and holds both
    // until it samples preset_ack; the slave pulses preset_ack for one cycle when it
    // accepts, and the master must drop preset_req before the ramp finishes.
    logic   preset_req;
    level_t preset_level;
    logic   preset_ack;

    modport master (output preset_req, output preset_level, input preset_ack);
    modport slave  (input preset_req, input preset_level, output preset_ack);

endinterface

// File: rtl/vol_ramp_ctrl_btn_edge.sv
// Active-low button synchronizer with press-edge detection; one pulse per press,
// and no pulse after reset release even if the button is already held.
module vol_btn_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic btn_n,
    output logic press
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   armed_q;
    logic                   prev_q;
    logic                   pressed;

    assign pressed = ~sync_q[SYNC_STAGES-1];

    // fill_q tracks when the last stage holds a real sample rather than the reset
    // value; edges are only reported one cycle later so prev_q is also real.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync_q  <= '1;
            fill_q  <= '0;
            armed_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync_q  <= (sync_q << 1) | SYNC_STAGES'(btn_n);
            fill_q  <= (fill_q << 1) | SYNC_STAGES'(1'b1);
            armed_q <= fill_q[SYNC_STAGES-1];
            prev_q  <= pressed;
        end
    end

    assign press = armed_q & pressed & ~prev_q;

endmodule

// File: rtl/vol_ramp_ctrl.sv
// Volume level controller: button up/down with saturation plus timed preset ramp.
// Optional VOL_RAMP_MUTE_EN adds an active-low Mute button that blanks Data.
module vol_ramp_ctrl
    import vol_pkg::*;
#(
    parameter int TICK_DIV    = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Vol_up,
    input  logic                 Vol_down,
`ifdef VOL_RAMP_MUTE_EN
    input  logic                 Mute,
`endif
    vol_ramp_ctrl_if.slave       preset,
    output logic [7:0]           Data,
    output level_t               hex_vol,
    output logic                 busy,
    output state_t               state_dbg
);
    localparam int             TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
    localparam level_t         LVL_MAX   = level_t'(MAX_LEVEL);

    state_t        state_q, state_d;
    level_t        lvl_q, lvl_d, tgt_q, tgt_d, lvl_up, lvl_dn;
    logic [TW-1:0] tick_q, tick_d;
    logic          ack_d, up_ev, dn_ev, mute_d;

    vol_btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_up (
        .Clk(Clk), .Reset(Reset), .btn_n(Vol_up), .press(up_ev));
    vol_btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dn (
        .Clk(Clk), .Reset(Reset), .btn_n(Vol_down), .press(dn_ev));

`ifdef VOL_RAMP_MUTE_EN
    logic mute_ev, mute_q;
    vol_btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mute (
        .Clk(Clk), .Reset(Reset), .btn_n(Mute), .press(mute_ev));
    assign mute_d = mute_q ^ mute_ev;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) mute_q <= 1'b0;
        else        mute_q <= mute_d;
    end
`else
    assign mute_d = 1'b0;
`endif

    assign lvl_up = (lvl_q == LVL_MAX) ? lvl_q : lvl_q + 4'd1;
    assign lvl_dn = (lvl_q == 4'd0)    ? lvl_q : lvl_q - 4'd1;

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        tgt_d   = tgt_q;
        tick_d  = tick_q;
        ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (preset.preset_req) begin
                    tgt_d   = (preset.preset_level > LVL_MAX) ? LVL_MAX : preset.preset_level;
                    ack_d   = 1'b1;
                    tick_d  = '0;
                    state_d = RAMP;
                end else if (up_ev && !dn_ev) begin
                    lvl_d = lvl_up;
                end else if (dn_ev && !up_ev) begin
                    lvl_d = lvl_dn;
                end
            end
            RAMP: begin
                // A button press is a manual override and wins over the ramp.
                if (up_ev || dn_ev) begin
                    if (up_ev && !dn_ev)      lvl_d = lvl_up;
                    else if (dn_ev && !up_ev) lvl_d = lvl_dn;
                    tgt_d   = lvl_d;
                    tick_d  = '0;
                    state_d = IDLE;
                end else if (lvl_q == tgt_q) begin
                    state_d = DONE;
                end else if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    lvl_d  = (tgt_q > lvl_q) ? lvl_q + 4'd1 : lvl_q - 4'd1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q           <= IDLE;
            lvl_q             <= '0;
            tgt_q             <= '0;
            tick_q            <= '0;
            Data              <= 8'h00;
            preset.preset_ack <= 1'b0;
        end else begin
            state_q           <= state_d;
            lvl_q             <= lvl_d;
            tgt_q             <= tgt_d;
            tick_q            <= tick_d;
            Data              <= mute_d ? 8'h00 : therm(lvl_d);
            preset.preset_ack <= ack_d;
        end
    end

    assign hex_vol   = lvl_q;
    assign busy      = (state_q == RAMP);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_vol_ramp_ctrl.sv
// Self-checking bench for vol_ramp_ctrl: level changes are checked against an
// expected queue; steady-state values are checked directly.
module tb_vol_ramp_ctrl;
    import vol_pkg::*;

    localparam int TICK_DIV = 4;

    logic   Clk = 1'b0;
    logic   Reset = 1'b0;
    logic   Vol_up = 1'b1;
    logic   Vol_down = 1'b1;
`ifdef VOL_RAMP_MUTE_EN
    logic   Mute = 1'b1;
`endif
    logic [7:0] Data;
    level_t     hex_vol;
    logic       busy;
    state_t     state_dbg;

    vol_ramp_ctrl_if pif();

    vol_ramp_ctrl #(.TICK_DIV(TICK_DIV), .SYNC_STAGES(2)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Vol_up(Vol_up),
        .Vol_down(Vol_down),
`ifdef VOL_RAMP_MUTE_EN
        .Mute(Mute),
`endif
        .preset(pif.slave),
        .Data(Data),
        .hex_vol(hex_vol),
        .busy(busy),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ack_cnt = 0;
    int mlvl    = 0;
    int ack_cyc = 0;
    logic [11:0] exp_q[$];
    int          chg_cyc[$];
    level_t      prev_hex = '0;
    logic [11:0] exp_item;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_data(input int l);
        logic [7:0] ones;
        ones = 8'hFF;
        if (l <= 0) return 8'h00;
        return ones >> (8 - l);
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge Clk) begin
        if (Reset && hex_vol !== prev_hex) begin
            chg_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_change", {20'd0, hex_vol, Data}, {20'd0, prev_hex, exp_data(int'(prev_hex))});
            end else begin
                exp_item = exp_q.pop_front();
                check("level_change", {20'd0, hex_vol, Data}, {20'd0, exp_item});
            end
        end
        if (Reset && pif.preset_ack) ack_cnt <= ack_cnt + 1;
        prev_hex <= hex_vol;
    end

    // ---------------- drivers ----------------
    task automatic push_lvl(input int l);
        exp_q.push_back({4'(l), exp_data(l)});
    endtask

    task automatic do_reset();
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        @(negedge Clk);
        Reset = 1'b0;
        pif.preset_req = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_hex", hex_vol, 0);
        check("rst_data", Data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_ack", pif.preset_ack, 0);
        check("rst_state", state_dbg, IDLE);
        Reset = 1'b1;
        mlvl = 0;
        repeat (6) @(negedge Clk);
    endtask

    // which: 0 = up, 1 = down, 2 = both. Called at a negedge.
    task automatic press(input int which);
        if (which != 1) Vol_up = 1'b0;
        if (which != 0) Vol_down = 1'b0;
        repeat (6) @(negedge Clk);
        Vol_up = 1'b1;
        Vol_down = 1'b1;
        repeat (6) @(negedge Clk);
    endtask

    task automatic press_up();
        if (mlvl < 8) begin mlvl++; push_lvl(mlvl); end
        press(0);
    endtask

    task automatic press_down();
        if (mlvl > 0) begin mlvl--; push_lvl(mlvl); end
        press(1);
    endtask

    // Issues a request, waits for ack, drops the request; returns at the ack negedge.
    task automatic do_preset(input int lvl);
        int t;
        pif.preset_level = 4'(lvl);
        pif.preset_req = 1'b1;
        t = 0;
        while (!pif.preset_ack && t < 20) begin
            @(negedge Clk);
            t++;
        end
        check("ack_seen", pif.preset_ack, 1);
        ack_cyc = cyc;
        pif.preset_req = 1'b0;
    endtask

    task automatic wait_idle(output bit seen_done);
        int t;
        t = 0;
        seen_done = 1'b0;
        while ((busy || state_dbg != IDLE) && t < 200) begin
            @(negedge Clk);
            if (state_dbg == DONE) seen_done = 1'b1;
            t++;
        end
        check("idle_timeout", t < 200, 1);
    endtask

    // ---------------- tests ----------------
    initial begin
        int n0;
        int a0;
        int t;
        bit seen;
        pif.preset_req = 1'b0;
        pif.preset_level = '0;

        // Three presses up.
        do_reset();
        repeat (3) press_up();
        check("up3_hex", hex_vol, 3);
        check("up3_data", Data, 8'h07);

        // Saturation at both ends.
        repeat (5) press_up();
        check("top_hex", hex_vol, 8);
        press_up();
        check("sat_top_hex", hex_vol, 8);
        check("sat_top_data", Data, 8'hFF);
        do_reset();
        press_down();
        check("sat_bot_hex", hex_vol, 0);
        check("sat_bot_data", Data, 8'h00);

        // Timed ramp 2 -> 6.
        do_reset();
        repeat (2) press_up();
        n0 = chg_cyc.size();
        a0 = ack_cnt;
        for (int l = 3; l <= 6; l++) push_lvl(l);
        do_preset(6);
        check("ramp_busy", busy, 1);
        wait_idle(seen);
        check("ramp_done_seen", seen, 1);
        check("ramp_ack_cnt", ack_cnt - a0, 1);
        check("ramp_hex", hex_vol, 6);
        check("ramp_busy_low", busy, 0);
        check("ramp_changes", chg_cyc.size() - n0, 4);
        if (chg_cyc.size() - n0 == 4) begin
            check("ramp_first_gap", chg_cyc[n0] - ack_cyc, 4);
            for (int k = 1; k < 4; k++)
                check("ramp_gap", chg_cyc[n0 + k] - chg_cyc[n0 + k - 1], 4);
        end
        mlvl = 6;

        // Out-of-range preset clamps at 8.
        do_reset();
        for (int l = 1; l <= 8; l++) push_lvl(l);
        do_preset(12);
        wait_idle(seen);
        check("clamp_hex", hex_vol, 8);
        check("clamp_data", Data, 8'hFF);

        // Preset equal to current level: ack, no step.
        do_reset();
        a0 = ack_cnt;
        do_preset(0);
        wait_idle(seen);
        check("same_done_seen", seen, 1);
        check("same_ack_cnt", ack_cnt - a0, 1);
        check("same_hex", hex_vol, 0);

        // Manual override aborts ramp 1 -> 7 at level 4.
        do_reset();
        press_up();
        for (int l = 2; l <= 4; l++) push_lvl(l);
        do_preset(7);
        t = 0;
        while (hex_vol != 4 && t < 100) begin @(negedge Clk); t++; end
        check("abort_reach4", hex_vol, 4);
        push_lvl(3);
        mlvl = 3;
        press(1);
        check("abort_hex", hex_vol, 3);
        check("abort_busy", busy, 0);
        check("abort_state", state_dbg, IDLE);
        repeat (20) @(negedge Clk);
        check("abort_stays", hex_vol, 3);

        // Reset mid-ramp with Vol_up held across release.
        do_reset();
        a0 = ack_cnt;
        do_preset(8);
        repeat (2) @(negedge Clk);
        Vol_up = 1'b0;
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        repeat (10) @(negedge Clk);
        Vol_up = 1'b1;
        repeat (30) @(negedge Clk);
        check("rstmid_hex", hex_vol, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_ack", ack_cnt - a0, 1);

        // Simultaneous up/down ignored.
        do_reset();
        repeat (5) press_up();
        press(2);
        check("both_hex", hex_vol, 5);
        check("both_data", Data, 8'h1F);
`ifdef VOL_RAMP_MUTE_EN
        Mute = 1'b0;
        repeat (6) @(negedge Clk);
        Mute = 1'b1;
        repeat (6) @(negedge Clk);
        check("mute_data", Data, 8'h00);
        check("mute_hex", hex_vol, 5);
        exp_q.push_back({4'd6, 8'h00});
        mlvl = 6;
        press(0);
        check("mute_up_hex", hex_vol, 6);
        check("mute_up_data", Data, 8'h00);
`endif

        repeat (4) @(negedge Clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
